// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider: request operands in, results and status out.
// SEQ_DIV_SIGNED_EN adds the is_signed request bit.
interface seq_divider_if;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
`ifdef SEQ_DIV_SIGNED_EN
   logic        is_signed;
`endif
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_zero;

   modport master (
`ifdef SEQ_DIV_SIGNED_EN
      output is_signed,
`endif
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
`ifdef SEQ_DIV_SIGNED_EN
      input  is_signed,
`endif
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/seq_divider.sv
// 16-bit restoring divider: one shared subtract unit stepped over 16 cycles, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for the two's-complement mode (is_signed input and FIX state).
module seq_divider (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
`ifdef SEQ_DIV_SIGNED_EN
      S_FIX,
`endif
      S_DONE
   } state_t;

   state_t      r_state;
   logic [15:0] r_dividend;
   logic [15:0] r_divisor;
   logic [15:0] r_rem;
   logic [15:0] r_quo;
   logic [3:0]  r_count;
   logic        r_busy;
   logic        r_done;
   logic        r_div_zero;
   logic [15:0] r_q_out;
   logic [15:0] r_r_out;
`ifdef SEQ_DIV_SIGNED_EN
   logic        r_is_signed;
   logic        r_neg_q;
   logic        r_neg_r;
`endif

   logic [15:0] w_trial;
   logic [16:0] w_sum;
   logic        w_ok;
   logic [15:0] w_rem_nxt;
   logic [15:0] w_quo_nxt;

   // Two's-complement negate, i.e. 0 - x through the same add-invert-plus-one path.
   function automatic logic [15:0] f_neg(input logic [15:0] x);
      return ~x + 16'd1;
   endfunction

   // Trial subtract T - D; carry-out set means no borrow. R[15] covers the 17th bit of T.
   always_comb begin
      w_trial   = {r_rem[14:0], r_quo[15]};
      w_sum     = {1'b0, w_trial} + {1'b0, ~r_divisor} + 17'd1;
      w_ok      = r_rem[15] | w_sum[16];
      w_rem_nxt = w_ok ? w_sum[15:0] : w_trial;
      w_quo_nxt = {r_quo[14:0], w_ok};
   end

   // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_dividend  <= 16'h0000;
         r_divisor   <= 16'h0000;
         r_rem       <= 16'h0000;
         r_quo       <= 16'h0000;
         r_count     <= 4'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_q_out     <= 16'h0000;
         r_r_out     <= 16'h0000;
`ifdef SEQ_DIV_SIGNED_EN
         r_is_signed <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_dividend  <= bus.dividend;
                  r_divisor   <= bus.divisor;
`ifdef SEQ_DIV_SIGNED_EN
                  r_is_signed <= bus.is_signed;
`endif
                  r_div_zero  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (r_divisor == 16'h0000) begin
                  r_q_out    <= 16'hFFFF;
                  r_r_out    <= r_dividend;
                  r_div_zero <= 1'b1;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_rem   <= 16'h0000;
                  r_count <= 4'd0;
`ifdef SEQ_DIV_SIGNED_EN
                  r_quo     <= (r_is_signed && r_dividend[15]) ? f_neg(r_dividend) : r_dividend;
                  r_divisor <= (r_is_signed && r_divisor[15])  ? f_neg(r_divisor)  : r_divisor;
                  r_neg_q   <= r_is_signed & (r_dividend[15] ^ r_divisor[15]);
                  r_neg_r   <= r_is_signed & r_dividend[15];
`else
                  r_quo     <= r_dividend;
`endif
                  r_state <= S_RUN;
               end
            end

            S_RUN: begin
               r_rem   <= w_rem_nxt;
               r_quo   <= w_quo_nxt;
               r_count <= r_count + 4'd1;
               if (r_count == 4'd15) begin
`ifdef SEQ_DIV_SIGNED_EN
                  r_state <= S_FIX;
`else
                  r_q_out <= w_quo_nxt;
                  r_r_out <= w_rem_nxt;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
`endif
               end
            end

`ifdef SEQ_DIV_SIGNED_EN
            // Magnitude -32768 / 1 yields 16'h8000, which already reads back as -32768.
            S_FIX: begin
               r_q_out <= r_neg_q ? f_neg(r_quo) : r_quo;
               r_r_out <= r_neg_r ? f_neg(r_rem) : r_rem;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
`endif

            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.quotient  = r_q_out;
   assign bus.remainder = r_r_out;
   assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands vs. an arithmetic model.
// Honours SEQ_DIV_SIGNED_EN when compiled with the same define as the RTL.
module tb_seq_divider;

`ifdef SEQ_DIV_SIGNED_EN
   localparam int LAT    = 19;
   localparam int PERIOD = 20;
`else
   localparam int LAT    = 18;
   localparam int PERIOD = 19;
`endif
   localparam int TMO = 60;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   cyc;

   seq_divider_if bus ();

   seq_divider u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: plain integer division; signed uses SV truncating '/' and '%'.
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                                   output logic [15:0] q, output logic [15:0] r, output logic z);
      int sa, sb;
      if (b == 16'h0000) begin
         q = 16'hFFFF; r = a; z = 1'b1;
      end else if (sgn) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         q  = 16'(sa / sb);
         r  = 16'(sa % sb);
         z  = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic sgn);
      bus.dividend = a;
      bus.divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
      bus.is_signed = sgn;
`else
      if (sgn) $display("note: signed request issued to unsigned build");
`endif
   endtask

   // One transaction from accept to the cycle after done; pulse_at>0 fires a stray start mid-run.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sgn, input int pulse_at);
      logic [15:0] eq, er;
      logic        ez;
      int          n;
      bit          seen;
      ref_div(a, b, sgn, eq, er, ez);
      drive_req(a, b, sgn);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("accept_busy", bus.busy, 1);
      check("accept_dz_clear", bus.div_zero, 0);
      n = 0; seen = 0;
      while (!seen && n < TMO) begin
         if (pulse_at > 0 && n == pulse_at) begin
            drive_req(16'($urandom), 16'($urandom_range(1, 65535)), sgn);
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (n == 1 && !ez) check("busy_in_run", bus.busy, 1);
         if (bus.done) seen = 1;
      end
      bus.start = 1'b0;
      check("done_seen", 32'(seen), 1);
      check("latency", 32'(n + 1), ez ? 32'd2 : 32'(LAT));
      check("busy_at_done", bus.busy, 0);
      check("quotient", bus.quotient, eq);
      check("remainder", bus.remainder, er);
      check("div_zero", bus.div_zero, ez);
      @(posedge clk); #1;
      check("done_one_cycle", bus.done, 0);
      check("held_quotient", bus.quotient, eq);
   endtask

   initial begin
      logic [15:0] ra, rb, eq, er;
      logic        rs, ez;
      int          c1, c2, n;
      bit          seen;
      n_checks = 0; n_errors = 0; cyc = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      drive_req(16'h0, 16'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_div_zero", bus.div_zero, 0);
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'd100, 16'd7, 1'b0, 0);
      run_op(16'hFFFF, 16'd1, 1'b0, 0);
      run_op(16'h1234, 16'hFFFF, 1'b0, 0);
      run_op(16'd5, 16'd0, 1'b0, 0);
      // Accept of the next request clears div_zero but leaves results alone.
      drive_req(16'd50, 16'd5, 1'b0);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("dz_cleared_at_accept", bus.div_zero, 0);
      check("result_held_at_accept", bus.quotient, 16'hFFFF);
      check("rem_held_at_accept", bus.remainder, 16'd5);
      n = 0;
      while (!bus.done && n < TMO) begin @(posedge clk); #1; n++; end
      check("after_dz_quotient", bus.quotient, 16'd10);
      @(posedge clk); #1;

      run_op(16'd200, 16'd9, 1'b0, 5);

      // start held high: one accept per IDLE visit.
      drive_req(16'd1000, 16'd33, 1'b0);
      bus.start = 1'b1;
      n = 0;
      while (!bus.done && n < TMO) begin @(posedge clk); #1; n++; end
      c1 = cyc;
      check("held_first_done", bus.done, 1);
      check("held_first_q", bus.quotient, 16'd30);
      @(posedge clk); #1;
      n = 0;
      while (!bus.done && n < TMO) begin @(posedge clk); #1; n++; end
      c2 = cyc;
      bus.start = 1'b0;
      check("held_second_done", bus.done, 1);
      check("held_period", 32'(c2 - c1), 32'(PERIOD));
      check("held_second_r", bus.remainder, 16'd10);
      repeat (2) @(posedge clk);
      #1;
      check("no_accept_after_drop", bus.busy, 0);

      // Asynchronous reset at RUN iteration 8.
      drive_req(16'd1000, 16'd3, 1'b0);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      seen = 0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_quotient", bus.quotient, 0);
      check("abort_remainder", bus.remainder, 0);
      check("abort_div_zero", bus.div_zero, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      check("no_done_after_abort", 32'(seen), 0);
      run_op(16'd9, 16'd3, 1'b0, 0);

`ifdef SEQ_DIV_SIGNED_EN
      run_op(16'hFF9C, 16'd7, 1'b1, 0);
      check("signed_neg100_q", bus.quotient, 16'hFFF2);
      run_op(16'h8000, 16'hFFFF, 1'b1, 0);
      check("signed_min_r", bus.remainder, 16'h0000);
      run_op(16'd100, 16'hFFF9, 1'b1, 0);
      run_op(16'hFF9C, 16'd0, 1'b1, 0);
`endif

      for (int k = 0; k < 40; k++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 9))
            0:       rb = 16'h0000;
            1, 2, 3: rb = 16'($urandom_range(1, 15));
            default: rb = 16'($urandom);
         endcase
`ifdef SEQ_DIV_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         ref_div(ra, rb, rs, eq, er, ez);
         run_op(ra, rb, rs, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
